// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire byte master: command codes, FSM states
// and slot timing constants expressed in microseconds.
package onewire_pkg;

  localparam logic [1:0] CMD_RESET = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_SLOT_LOW,
    ST_SLOT_REL,
    ST_RECOVER,
    ST_DONE
  } state_t;

  localparam int T_RST_LOW     = 480;
  localparam int T_PRES_SAMPLE = 70;
  localparam int T_SLOT        = 60;
  localparam int T_LOW1        = 6;
  localparam int T_RSAMPLE     = 15;
  localparam int T_REC         = 10;

endpackage

// File: rtl/onewire_crc8.sv
// Bit-serial Dallas CRC-8 (reflected poly 0x8C) with update enable and a
// synchronous clear that takes priority over an update.
module onewire_crc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       fb;

  // Next CRC value for one incoming bit, LSB-first.
  always_comb begin
    fb    = crc_q[0] ^ bit_i;
    crc_d = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);
  end

  // CRC register: clear first, otherwise update on each sampled bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else if (clr_i) begin
      crc_q <= 8'h00;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/onewire_master.sv
// Byte-level 1-Wire bus master: reset/presence, write and read slots.
// The pad is open-drain; pad_oe=1 pulls the bus low, pad_out is tied 0.
// Optional CRC-8 over read bits: define ONEWIRE_MASTER_CRC_EN.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int CYCLES_PER_US = 12,
  parameter int W_CTR         = $clog2(960*CYCLES_PER_US+1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       rsp_valid,
  output logic [7:0] rdata,
  output logic       presence,
  output logic       pad_out,
  output logic       pad_oe,
  input  logic       pad_in
`ifdef ONEWIRE_MASTER_CRC_EN
  ,
  input  logic       crc_clr,
  output logic [7:0] crc
`endif
);

  localparam logic [W_CTR-1:0] TMR_ONE  = W_CTR'(1);
  localparam logic [W_CTR-1:0] RST_END  = W_CTR'(T_RST_LOW*CYCLES_PER_US - 1);
  localparam logic [W_CTR-1:0] PRES_AT  = W_CTR'(T_PRES_SAMPLE*CYCLES_PER_US);
  localparam logic [W_CTR-1:0] SLOT_END = W_CTR'(T_SLOT*CYCLES_PER_US - 1);
  localparam logic [W_CTR-1:0] LOW1_END = W_CTR'(T_LOW1*CYCLES_PER_US - 1);
  localparam logic [W_CTR-1:0] RSAMP_AT = W_CTR'(T_RSAMPLE*CYCLES_PER_US);
  localparam logic [W_CTR-1:0] REC_END  = W_CTR'(T_REC*CYCLES_PER_US - 1);

  state_t           state_q;
  logic [W_CTR-1:0] timer_q;
  logic [2:0]       bit_q;
  logic [1:0]       cmd_q;
  logic [7:0]       wdata_q;
  logic [7:0]       shadow_q;
  logic [7:0]       rdata_q;
  logic             presence_q;
  logic             oe_q;
  logic             rsp_q;
  logic [1:0]       sync_q;
  logic             pad_sync;
  logic             long_low;
  logic             rd_sample;

  // Two-flop synchroniser for the asynchronous bus input; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pad_in};
    end
  end

  assign pad_sync  = sync_q[1];
  assign long_low  = (cmd_q == CMD_WRITE) && !wdata_q[bit_q];
  assign rd_sample = (state_q == ST_SLOT_REL) && (cmd_q == CMD_READ) && (timer_q == RSAMP_AT);

  // Command sequencer: slot timing, bit shifting and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_q      <= 3'd0;
      cmd_q      <= CMD_RESET;
      wdata_q    <= 8'h00;
      shadow_q   <= 8'h00;
      rdata_q    <= 8'h00;
      presence_q <= 1'b0;
      oe_q       <= 1'b0;
      rsp_q      <= 1'b0;
    end else begin
      rsp_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q   <= cmd;
            wdata_q <= wdata;
            timer_q <= '0;
            bit_q   <= 3'd0;
            case (cmd)
              CMD_RESET: begin
                state_q <= ST_RST_LOW;
                oe_q    <= 1'b1;
              end
              CMD_WRITE, CMD_READ: begin
                state_q <= ST_SLOT_LOW;
                oe_q    <= 1'b1;
              end
              default: begin
                state_q <= ST_DONE;
                rsp_q   <= 1'b1;
              end
            endcase
          end
        end
        ST_RST_LOW: begin
          if (timer_q == RST_END) begin
            state_q <= ST_RST_WAIT;
            timer_q <= '0;
            oe_q    <= 1'b0;
          end else begin
            timer_q <= timer_q + TMR_ONE;
          end
        end
        ST_RST_WAIT: begin
          if (timer_q == PRES_AT) begin
            presence_q <= ~pad_sync;
          end
          if (timer_q == RST_END) begin
            state_q <= ST_DONE;
            timer_q <= '0;
            rsp_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_ONE;
          end
        end
        ST_SLOT_LOW: begin
          if (long_low && (timer_q == SLOT_END)) begin
            state_q <= ST_RECOVER;
            timer_q <= '0;
            oe_q    <= 1'b0;
          end else begin
            timer_q <= timer_q + TMR_ONE;
            if (!long_low && (timer_q == LOW1_END)) begin
              state_q <= ST_SLOT_REL;
              oe_q    <= 1'b0;
            end
          end
        end
        ST_SLOT_REL: begin
          if (rd_sample) begin
            shadow_q <= {pad_sync, shadow_q[7:1]};
          end
          if (timer_q == SLOT_END) begin
            state_q <= ST_RECOVER;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TMR_ONE;
          end
        end
        ST_RECOVER: begin
          if (timer_q == REC_END) begin
            timer_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= ST_DONE;
              bit_q   <= 3'd0;
              rsp_q   <= 1'b1;
              if (cmd_q == CMD_READ) begin
                rdata_q <= shadow_q;
              end
            end else begin
              state_q <= ST_SLOT_LOW;
              bit_q   <= bit_q + 3'd1;
              oe_q    <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + TMR_ONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_q;
  assign rdata     = rdata_q;
  assign presence  = presence_q;
  assign pad_oe    = oe_q;
  assign pad_out   = 1'b0;

`ifdef ONEWIRE_MASTER_CRC_EN
  logic crc_zero;

  // A RESET command starts a fresh ROM read, so it also clears the CRC.
  assign crc_zero = crc_clr || (cmd_ready && cmd_valid && (cmd == CMD_RESET));

  onewire_crc8 u_crc (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rd_sample),
    .clr_i (crc_zero),
    .bit_i (pad_sync),
    .crc_o (crc)
  );
`endif

endmodule
